// File: rtl/dig_pkg.sv
// Shared constants for the scanned 7-segment driver: segment width,
// polarity and the glyph table, bit order [0:6] = a..g, active-low.
package dig_pkg;

  localparam int SEG_W = 7;

  // Pins are active-low: driving 0 lights a segment / enables an anode.
  localparam logic SEG_ON  = 1'b0;
  localparam logic SEG_OFF = 1'b1;

  typedef logic [0:SEG_W-1] seg_t;

  localparam seg_t GLYPH_0     = 7'b0000001;
  localparam seg_t GLYPH_1     = 7'b1001111;
  localparam seg_t GLYPH_2     = 7'b0010010;
  localparam seg_t GLYPH_3     = 7'b0000110;
  localparam seg_t GLYPH_4     = 7'b1001100;
  localparam seg_t GLYPH_5     = 7'b0100100;
  localparam seg_t GLYPH_6     = 7'b0100000;
  localparam seg_t GLYPH_7     = 7'b0001111;
  localparam seg_t GLYPH_8     = 7'b0000000;
  localparam seg_t GLYPH_9     = 7'b0000100;
  localparam seg_t GLYPH_A     = 7'b0001000;
  localparam seg_t GLYPH_B     = 7'b1100000;
  localparam seg_t GLYPH_C     = 7'b0110001;
  localparam seg_t GLYPH_D     = 7'b1000010;
  localparam seg_t GLYPH_E     = 7'b0110000;
  localparam seg_t GLYPH_F     = 7'b0111000;
  localparam seg_t GLYPH_BLANK = 7'b1111111;

endpackage

// File: rtl/dig_glyph.sv
// Nibble to 7-segment glyph lookup; hex digits render blank unless hex_en.
module dig_glyph
  import dig_pkg::*;
(
  input  logic [3:0]       nibble,
  input  logic             hex_en,
  output logic [0:SEG_W-1] seg
);

  // Pure table lookup on the currently scanned nibble.
  always_comb begin
    seg = GLYPH_BLANK;
    case (nibble)
      4'h0: seg = GLYPH_0;
      4'h1: seg = GLYPH_1;
      4'h2: seg = GLYPH_2;
      4'h3: seg = GLYPH_3;
      4'h4: seg = GLYPH_4;
      4'h5: seg = GLYPH_5;
      4'h6: seg = GLYPH_6;
      4'h7: seg = GLYPH_7;
      4'h8: seg = GLYPH_8;
      4'h9: seg = GLYPH_9;
      4'hA: seg = hex_en ? GLYPH_A : GLYPH_BLANK;
      4'hB: seg = hex_en ? GLYPH_B : GLYPH_BLANK;
      4'hC: seg = hex_en ? GLYPH_C : GLYPH_BLANK;
      4'hD: seg = hex_en ? GLYPH_D : GLYPH_BLANK;
      4'hE: seg = hex_en ? GLYPH_E : GLYPH_BLANK;
      4'hF: seg = hex_en ? GLYPH_F : GLYPH_BLANK;
      default: seg = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/dig_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver: slot/digit/frame counters,
// double-buffered display contents swapped only at frame boundaries,
// leading-zero suppression, blink, dead time and fully registered pins.
module dig_scan_driver
  import dig_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int DEAD         = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic                    hex_en,
  input  logic                    lz_en,
  input  logic                    blank,
  output logic [0:SEG_W-1]        seg,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

  // Counter state
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [FRM_W-1:0]  frame_q, frame_d;
  logic              phase_q, phase_d;

  // Display (shown) and pending (CPU-written) buffers
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d, pend_q, pend_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0]   disp_bl_q, disp_bl_d, pend_bl_q, pend_bl_d;
  logic                    pend_valid_q, pend_valid_d;

  // Registered pin drivers
  logic [0:SEG_W-1]      seg_q, seg_d;
  logic                  dp_n_q, dp_n_d;
  logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
  logic                  frame_done_q, frame_done_d;

  logic                  slot_end, frame_end, in_dead;
  logic [3:0]            nib_w [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] zero_hi;
  logic [3:0]            cur_nib;
  logic                  cur_sup, cur_dark;
  logic [0:SEG_W-1]      glyph_seg;

  // Per-digit nibble view and "this digit and all above are zero" flags.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign nib_w[gi]   = disp_q[4*gi +: 4];
    assign zero_hi[gi] = (disp_q[4*NUM_DIGITS-1:4*gi] == '0);
  end

  assign slot_end  = (slot_q == SLOT_LAST);
  assign frame_end = slot_end && (idx_q == IDX_LAST);
  assign in_dead   = (int'(slot_q) < DEAD);
  assign cur_nib   = nib_w[idx_q];
  assign cur_sup   = lz_en && (idx_q != '0) && zero_hi[idx_q];
  assign cur_dark  = disp_bl_q[idx_q] && phase_q;

  dig_glyph u_glyph (
    .nibble (cur_nib),
    .hex_en (hex_en),
    .seg    (glyph_seg)
  );

  // Next-state: counters, frame-aligned buffer swap, and pin values for this slot.
  always_comb begin
    slot_d       = slot_q + SLOT_W'(1);
    idx_d        = idx_q;
    frame_d      = frame_q;
    phase_d      = phase_q;
    disp_d       = disp_q;
    disp_dp_d    = disp_dp_q;
    disp_bl_d    = disp_bl_q;
    pend_d       = pend_q;
    pend_dp_d    = pend_dp_q;
    pend_bl_d    = pend_bl_q;
    pend_valid_d = pend_valid_q;

    if (slot_end) begin
      slot_d = '0;
      idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    if (frame_end) begin
      if (frame_q == FRM_LAST) begin
        frame_d = '0;
        phase_d = ~phase_q;
      end else begin
        frame_d = frame_q + FRM_W'(1);
      end
      // The swap uses the pending contents from before this edge, so a
      // coincident load lands in pending and waits for the next frame.
      if (pend_valid_q) begin
        disp_d       = pend_q;
        disp_dp_d    = pend_dp_q;
        disp_bl_d    = pend_bl_q;
        pend_valid_d = 1'b0;
      end
    end

    if (load) begin
      pend_d       = value;
      pend_dp_d    = dp_in;
      pend_bl_d    = blink_en;
      pend_valid_d = 1'b1;
    end

    seg_d        = (cur_sup || cur_dark) ? GLYPH_BLANK : glyph_seg;
    dp_n_d       = cur_dark ? SEG_OFF : ~disp_dp_q[idx_q];
    an_n_d       = (blank || in_dead) ? '1 : ~(NUM_DIGITS'(1) << idx_q);
    frame_done_d = frame_end;
  end

  // State and pin registers with asynchronous reset to a dark display.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q       <= '0;
      idx_q        <= '0;
      frame_q      <= '0;
      phase_q      <= 1'b0;
      disp_q       <= '0;
      disp_dp_q    <= '0;
      disp_bl_q    <= '0;
      pend_q       <= '0;
      pend_dp_q    <= '0;
      pend_bl_q    <= '0;
      pend_valid_q <= 1'b0;
      seg_q        <= GLYPH_BLANK;
      dp_n_q       <= SEG_OFF;
      an_n_q       <= '1;
      frame_done_q <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      idx_q        <= idx_d;
      frame_q      <= frame_d;
      phase_q      <= phase_d;
      disp_q       <= disp_d;
      disp_dp_q    <= disp_dp_d;
      disp_bl_q    <= disp_bl_d;
      pend_q       <= pend_d;
      pend_dp_q    <= pend_dp_d;
      pend_bl_q    <= pend_bl_d;
      pend_valid_q <= pend_valid_d;
      seg_q        <= seg_d;
      dp_n_q       <= dp_n_d;
      an_n_q       <= an_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp_n       = dp_n_q;
  assign an_n       = an_n_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_dig_scan_driver.sv
// Scoreboard bench for dig_scan_driver: a behavioural model derives every
// cycle's expected pins from the cycle count since reset, pushes them into
// a queue, and a negedge monitor pops and compares against the pins.
module tb_dig_scan_driver;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int DT = 1;
  localparam int BF = 2;
  localparam int FRAME = SD * ND;

  logic          clk;
  logic          rst;
  logic [15:0]   value;
  logic          load;
  logic [3:0]    dp_in;
  logic [3:0]    blink_en;
  logic          hex_en;
  logic          lz_en;
  logic          blank;
  logic [0:6]    seg;
  logic          dp_n;
  logic [3:0]    an_n;
  logic          frame_done;

  int checks   = 0;
  int failures = 0;

  dig_scan_driver #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (SD),
    .DEAD         (DT),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .load       (load),
    .dp_in      (dp_in),
    .blink_en   (blink_en),
    .hex_en     (hex_en),
    .lz_en      (lz_en),
    .blank      (blank),
    .seg        (seg),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Glyph table, leftmost character = segment a.
  logic [6:0] gtab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got seg/dp/an/fd=%b_%b_%b_%b expected %b_%b_%b_%b",
               name, $time, act[12:6], act[5], act[4:1], act[0],
               exp[12:6], exp[5], exp[4:1], exp[0]);
    end
  endtask

  // Reference model state
  logic [12:0] exp_q [$];
  int          n = 0;
  logic [15:0] m_disp = '0, m_pend = '0;
  logic [3:0]  m_dp = '0, m_bl = '0, m_pdp = '0, m_pbl = '0;
  bit          m_pv = 0;
  int          m_slot, m_dig, m_frame;
  bit          m_phase, m_sup, m_dark, m_fd, m_dpn;
  logic [3:0]  m_nib, m_an;
  logic [6:0]  m_seg;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      n = 0; m_disp = '0; m_pend = '0; m_dp = '0; m_bl = '0;
      m_pdp = '0; m_pbl = '0; m_pv = 0;
    end else begin
      m_slot  = n % SD;
      m_dig   = (n / SD) % ND;
      m_frame = n / FRAME;
      m_phase = ((m_frame / BF) % 2) == 1;
      m_nib   = m_disp[4*m_dig +: 4];
      m_sup   = lz_en && (m_dig > 0) && ((m_disp >> (4*m_dig)) == 16'h0);
      m_dark  = m_bl[m_dig] && m_phase;
      if (m_sup || m_dark)         m_seg = 7'h7F;
      else if (m_nib > 9 && !hex_en) m_seg = 7'h7F;
      else                         m_seg = gtab[m_nib];
      m_dpn   = m_dark ? 1'b1 : !m_dp[m_dig];
      m_an    = (blank || m_slot < DT) ? 4'hF : ~(4'b0001 << m_dig);
      m_fd    = (m_slot == SD-1) && (m_dig == ND-1);
      exp_q.push_back({m_seg, m_dpn, m_an, m_fd});
      if (m_fd && m_pv) begin
        m_disp = m_pend; m_dp = m_pdp; m_bl = m_pbl; m_pv = 0;
      end
      if (load) begin
        m_pend = value; m_pdp = dp_in; m_pbl = blink_en; m_pv = 1;
      end
      n++;
    end
  end

  // Monitor: pins held dark under reset, otherwise match the model queue.
  logic [12:0] mon_exp;
  always @(negedge clk) begin
    if (rst) begin
      chk("reset_pins", {seg, dp_n, an_n, frame_done}, 13'b1111111_1_1111_0);
    end else if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      chk("scan_pins", {seg, dp_n, an_n, frame_done}, mon_exp);
    end
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
    value = v; dp_in = dp; blink_en = bl; load = 1'b1;
    tick(1);
    load = 1'b0;
  endtask

  // Advance until the next edge sees the given position within a frame.
  task automatic wait_phase(input int target);
    for (int i = 0; i < FRAME && (n % FRAME) != target; i++) tick(1);
  endtask

  initial begin
    rst = 1'b1; value = '0; load = 1'b0; dp_in = '0; blink_en = '0;
    hex_en = 1'b0; lz_en = 1'b0; blank = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(20);

    // Plain digits 1234
    do_load(16'h1234, 4'b0000, 4'b0000);
    tick(48);

    // Hex nibble and leading-zero suppression, then hex enabled live
    lz_en = 1'b1;
    do_load(16'h00A7, 4'b0100, 4'b0000);
    tick(32);
    hex_en = 1'b1;
    tick(32);

    // All-zero value with suppression: only digit 0 shows
    do_load(16'h0000, 4'b0000, 4'b0000);
    tick(32);
    lz_en = 1'b0;

    // Last load wins mid-frame; a load on the boundary waits one frame
    wait_phase(5);
    do_load(16'h1111, 4'b0000, 4'b0000);
    tick(1);
    do_load(16'h2222, 4'b0001, 4'b0000);
    tick(20);
    wait_phase(15);
    do_load(16'h5678, 4'b0000, 4'b0000);
    tick(40);

    // Blink on digit 0 across several blink periods, then blank mid-slot
    do_load(16'h8888, 4'b1011, 4'b0001);
    tick(FRAME * 9);
    wait_phase(6);
    blank = 1'b1;
    tick(10);
    blank = 1'b0;
    tick(20);

    // Randomised loads and live controls
    repeat (40) begin
      hex_en = 1'($urandom_range(0, 1));
      lz_en  = 1'($urandom_range(0, 1));
      blank  = ($urandom_range(0, 7) == 0);
      do_load(16'($urandom), 4'($urandom), 4'($urandom));
      tick($urandom_range(1, 20));
    end
    blank = 1'b0;
    do_load(16'h9A3C, 4'b0110, 4'b0000);
    tick(40);

    // Asynchronous reset mid-slot while digit 2 is lit
    wait_phase(10);
    rst = 1'b1;
    #1;
    chk("async_reset", {seg, dp_n, an_n, frame_done}, 13'b1111111_1_1111_0);
    tick(2);
    rst = 1'b0;
    tick(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
